// File: rtl/mutative_types.sv
// mutative_types: shared types for the dfp line bridge.
//   BRIDGE_BEATS / BRIDGE_BURST_W : line geometry (4 x 64-bit beats = 256-bit line)
//   bridge_state_t                : bridge FSM state encoding
//   line_beats_t                  : a cache line viewed as an array of burst beats
//   sat_inc32 / sat_inc16         : saturating increment helpers for the perf counters
package mutative_types;

  localparam int BRIDGE_BEATS   = 4;
  localparam int BRIDGE_BURST_W = 64;
  localparam int BRIDGE_CNT_W   = $clog2(BRIDGE_BEATS);

  typedef logic [BRIDGE_CNT_W-1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BRIDGE_BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ_REQ  = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } bridge_state_t;

  typedef logic [BRIDGE_BEATS-1:0][BRIDGE_BURST_W-1:0] line_beats_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != '1)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/dfp_line_bridge_if.sv
// dfp_line_bridge_if: bundles the cache-side dfp port and the burst-memory
// bmem port of the line bridge.
//   slave  : bridge view (answers dfp requests, drives bmem commands/beats)
//   master : environment view (cache issues dfp requests, memory answers bmem)
interface dfp_line_bridge_if;
  import mutative_types::*;

  // cache side
  logic [31:0]               dfp_addr;
  logic                      dfp_read;
  logic                      dfp_write;
  line_beats_t               dfp_wdata;
  line_beats_t               dfp_rdata;
  logic                      dfp_resp;
  // burst memory side
  logic [31:0]               bmem_addr;
  logic                      bmem_read;
  logic                      bmem_write;
  logic [BRIDGE_BURST_W-1:0] bmem_wdata;
  logic                      bmem_ready;
  logic [31:0]               bmem_raddr;
  logic [BRIDGE_BURST_W-1:0] bmem_rdata;
  logic                      bmem_rvalid;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

endinterface

// File: rtl/dfp_beat_buffer.sv
// dfp_beat_buffer: one cache line held as BRIDGE_BEATS burst beats.
//   clk, rst_n : clock, async active-low reset (clears the line)
//   load_en    : replace the whole line with load_line (takes priority)
//   wr_en      : overwrite beat idx with wr_beat
//   idx        : beat index shared by the write and read ports
//   rd_beat    : beat idx of the stored line
//   line       : the stored line
module dfp_beat_buffer
  import mutative_types::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_en,
  input  line_beats_t               load_line,
  input  logic                      wr_en,
  input  beat_idx_t                 idx,
  input  logic [BRIDGE_BURST_W-1:0] wr_beat,
  output logic [BRIDGE_BURST_W-1:0] rd_beat,
  output line_beats_t               line
);

  line_beats_t line_q, line_d;

  always_comb begin
    // NOTE: default assignment first so no path through this block leaves line_d unassigned (no latch).
    line_d = line_q;
    if (load_en) begin
      line_d = load_line;
    end else if (wr_en) begin
      line_d[idx] = wr_beat;
    end
  end

  // NOTE: the line is plain flops, not a RAM macro, so it is cleared on reset; a mid-burst reset must not leave stale beats visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      // NOTE: non-blocking assignment for every flop so all state updates see pre-edge values.
      line_q <= line_d;
    end
  end

  assign rd_beat = line_q[idx];
  assign line    = line_q;

endmodule

// File: rtl/dfp_line_bridge.sv
// dfp_line_bridge: services one 256-bit dfp line read/write as four 64-bit
// bmem beats and returns a one-cycle dfp_resp when the line is done.
//   clk, rst_n : clock, async active-low reset
//   bus        : dfp_line_bridge_if.slave (dfp request/response + bmem burst port)
// Optional build macro DFP_BRIDGE_PERF_EN adds saturating perf counters:
//   perf_rd_lines, perf_wr_lines, perf_stall_cycles (32 bit), perf_drop_beats (16 bit)
module dfp_line_bridge
  import mutative_types::*;
(
  input  logic               clk,
  input  logic               rst_n,
  dfp_line_bridge_if.slave   bus
`ifdef DFP_BRIDGE_PERF_EN
  ,
  output logic [31:0]        perf_rd_lines,
  output logic [31:0]        perf_wr_lines,
  output logic [31:0]        perf_stall_cycles,
  output logic [15:0]        perf_drop_beats
`endif
);

  bridge_state_t state_q, state_d;
  beat_idx_t     cnt_q,   cnt_d;
  logic [31:0]   addr_q,  addr_d;
  line_beats_t   rdata_q, rdata_d;

  logic                      buf_load, buf_wr;
  logic [BRIDGE_BURST_W-1:0] buf_rd_beat;
  line_beats_t               buf_line;
  line_beats_t               assembled;
  logic                      beat_ok;

  // Only beats tagged with the line we asked for count; anything else is dropped.
  assign beat_ok = bus.bmem_rvalid && (bus.bmem_raddr == addr_q);

  dfp_beat_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (buf_load),
    .load_line (bus.dfp_wdata),
    .wr_en     (buf_wr),
    .idx       (cnt_q),
    .wr_beat   (bus.bmem_rdata),
    .rd_beat   (buf_rd_beat),
    .line      (buf_line)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    buf_load = 1'b0;
    buf_wr   = 1'b0;
    // The buffer only holds the last beat after the edge, so the completed
    // line is formed here to publish dfp_rdata in the same cycle.
    assembled        = buf_line;
    assembled[cnt_q] = bus.bmem_rdata;

    case (state_q)
      ST_IDLE: begin
        if (bus.dfp_write) begin
          addr_d   = bus.dfp_addr & ~32'h1F;
          cnt_d    = '0;
          buf_load = 1'b1;
          state_d  = ST_WRITE;
        end else if (bus.dfp_read) begin
          addr_d  = bus.dfp_addr & ~32'h1F;
          cnt_d   = '0;
          state_d = ST_READ_REQ;
        end
      end
      ST_WRITE: begin
        if (bus.bmem_ready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + beat_idx_t'(1);
          end
        end
      end
      ST_READ_REQ: begin
        if (bus.bmem_ready) begin
          cnt_d   = '0;
          state_d = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        if (beat_ok) begin
          buf_wr = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            rdata_d = assembled;
            cnt_d   = '0;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + beat_idx_t'(1);
          end
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.dfp_resp   = (state_q == ST_RESP);
  assign bus.dfp_rdata  = rdata_q;
  assign bus.bmem_addr  = addr_q;
  assign bus.bmem_read  = (state_q == ST_READ_REQ);
  assign bus.bmem_write = (state_q == ST_WRITE);
  assign bus.bmem_wdata = (state_q == ST_WRITE) ? buf_rd_beat : '0;

`ifdef DFP_BRIDGE_PERF_EN
  logic [31:0] perf_rd_q,    perf_rd_d;
  logic [31:0] perf_wr_q,    perf_wr_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_drop_q,  perf_drop_d;
  logic        rd_done, wr_done, stall, drop;

  always_comb begin
    rd_done = (state_q == ST_READ_WAIT) && beat_ok && (cnt_q == LAST_BEAT);
    wr_done = (state_q == ST_WRITE) && bus.bmem_ready && (cnt_q == LAST_BEAT);
    stall   = (((state_q == ST_WRITE) || (state_q == ST_READ_REQ)) && !bus.bmem_ready)
           || ((state_q == ST_READ_WAIT) && !beat_ok);
    drop    = (state_q == ST_READ_WAIT) && bus.bmem_rvalid && !beat_ok;
    perf_rd_d    = sat_inc32(perf_rd_q, rd_done);
    perf_wr_d    = sat_inc32(perf_wr_q, wr_done);
    perf_stall_d = sat_inc32(perf_stall_q, stall);
    perf_drop_d  = sat_inc16(perf_drop_q, drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      perf_rd_q    <= perf_rd_d;
      perf_wr_q    <= perf_wr_d;
      perf_stall_q <= perf_stall_d;
      perf_drop_q  <= perf_drop_d;
    end
  end

  assign perf_rd_lines     = perf_rd_q;
  assign perf_wr_lines     = perf_wr_q;
  assign perf_stall_cycles = perf_stall_q;
  assign perf_drop_beats   = perf_drop_q;
`endif

endmodule

// File: tb/tb_dfp_line_bridge.sv
// tb_dfp_line_bridge: self-checking bench for dfp_line_bridge. Acts as both
// the cache and the burst memory, and predicts every bridge output from the
// line transfer rules (aligned address, beat order, drop rules, response
// timing, perf counts when DFP_BRIDGE_PERF_EN is defined).
module tb_dfp_line_bridge;
  import mutative_types::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  dfp_line_bridge_if bus();

`ifdef DFP_BRIDGE_PERF_EN
  logic [31:0] perf_rd_lines, perf_wr_lines, perf_stall_cycles;
  logic [15:0] perf_drop_beats;
`endif

  dfp_line_bridge dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus)
`ifdef DFP_BRIDGE_PERF_EN
    ,
    .perf_rd_lines     (perf_rd_lines),
    .perf_wr_lines     (perf_wr_lines),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_drop_beats   (perf_drop_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish (observed running, required done)");
    $fatal(1, "timeout");
  end

  // Reference model state
  line_beats_t exp_rdata;
  int          exp_rd, exp_wr, exp_stall, exp_drop;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    exp_rdata = '0;
    exp_rd    = 0;
    exp_wr    = 0;
    exp_stall = 0;
    exp_drop  = 0;
  endtask

  task automatic idle_inputs();
    bus.dfp_read    = 1'b0;
    bus.dfp_write   = 1'b0;
    bus.bmem_ready  = 1'b0;
    bus.bmem_rvalid = 1'b0;
  endtask

  task automatic check_perf(input string tag);
`ifdef DFP_BRIDGE_PERF_EN
    check({tag, "_perf_rd"},    perf_rd_lines,     exp_rd);
    check({tag, "_perf_wr"},    perf_wr_lines,     exp_wr);
    check({tag, "_perf_stall"}, perf_stall_cycles, exp_stall);
    check({tag, "_perf_drop"},  perf_drop_beats,   exp_drop);
`else
    check({tag, "_rdata_model"}, bus.dfp_rdata, exp_rdata);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_resp"},   bus.dfp_resp,   '0);
    check({tag, "_bread"},  bus.bmem_read,  '0);
    check({tag, "_bwrite"}, bus.bmem_write, '0);
    check({tag, "_baddr"},  bus.bmem_addr,  '0);
    check({tag, "_bwdata"}, bus.bmem_wdata, '0);
    check({tag, "_rdata"},  bus.dfp_rdata,  '0);
    check_perf(tag);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic line_beats_t rand_line();
    line_beats_t l;
    for (int i = 0; i < BRIDGE_BEATS; i++) l[i] = {$urandom, $urandom};
    return l;
  endfunction

  // Entered and left at #1 after a rising edge; leaves in the idle cycle after dfp_resp.
  task automatic do_write(input logic [31:0] addr, input line_beats_t line, input bit rand_ready);
    logic [31:0] aligned;
    int          i, n;
    bit          rdy;
    aligned = {addr[31:5], 5'b0};
    bus.dfp_write = 1'b1;
    bus.dfp_read  = 1'b0;
    bus.dfp_addr  = addr;
    bus.dfp_wdata = line;
    step();
    i = 0;
    n = 0;
    while (i < BRIDGE_BEATS && n < 64) begin
      check("wr_bwrite", bus.bmem_write, 1'b1);
      check("wr_baddr",  bus.bmem_addr,  aligned);
      check("wr_bwdata", bus.bmem_wdata, line[i]);
      check("wr_noresp", bus.dfp_resp,   1'b0);
      rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.bmem_ready = rdy;
      // Stray read beats outside READ_WAIT must be ignored.
      bus.bmem_rvalid = rand_ready && ($urandom_range(0, 3) == 0);
      bus.bmem_raddr  = aligned;
      bus.bmem_rdata  = {$urandom, $urandom};
      if (!rdy) exp_stall++;
      step();
      if (rdy) i++;
      n++;
    end
    if (i < BRIDGE_BEATS) check("wr_budget", n, 0);
    bus.bmem_ready  = 1'b0;
    bus.bmem_rvalid = 1'b0;
    exp_wr++;
    check("wr_resp",       bus.dfp_resp,   1'b1);
    check("wr_resp_nowr",  bus.bmem_write, 1'b0);
    check("wr_rdata_keep", bus.dfp_rdata,  exp_rdata);
    bus.dfp_write = 1'b0;
    step();
    check("wr_resp_pulse", bus.dfp_resp, 1'b0);
  endtask

  // abort_after >= 0: assert reset while waiting for that beat index.
  task automatic do_read(input logic [31:0] addr, input int req_stall, input int fixed_gap,
                         input bit rand_mode, input int drop_slot, input int abort_after);
    logic [31:0] aligned, drop_addr;
    line_beats_t exp_line;
    int          ng;
    bit          drop;
    aligned   = {addr[31:5], 5'b0};
    drop_addr = (aligned == 32'hDEAD_0000) ? 32'hBEEF_0000 : 32'hDEAD_0000;
    bus.dfp_read  = 1'b1;
    bus.dfp_write = 1'b0;
    bus.dfp_addr  = addr;
    step();
    for (int k = 0; k < req_stall; k++) begin
      check("rdreq_bread", bus.bmem_read, 1'b1);
      check("rdreq_baddr", bus.bmem_addr, aligned);
      check("rdreq_noresp", bus.dfp_resp, 1'b0);
      bus.bmem_ready  = 1'b0;
      bus.bmem_rvalid = 1'b1;
      bus.bmem_raddr  = aligned;
      bus.bmem_rdata  = {$urandom, $urandom};
      exp_stall++;
      step();
    end
    check("rdreq_bread", bus.bmem_read, 1'b1);
    check("rdreq_baddr", bus.bmem_addr, aligned);
    bus.bmem_ready  = 1'b1;
    bus.bmem_rvalid = 1'b0;
    step();
    bus.bmem_ready = 1'b0;
    check("rd_cmd_done", bus.bmem_read, 1'b0);
    for (int i = 0; i < BRIDGE_BEATS; i++) begin
      ng = rand_mode ? int'($urandom_range(0, 2)) : ((i > 0) ? fixed_gap : 0);
      if (i == drop_slot) ng++;
      for (int g = 0; g < ng; g++) begin
        check("rd_gap_noresp", bus.dfp_resp, 1'b0);
        drop = ((i == drop_slot) && (g == 0)) || (rand_mode && ($urandom_range(0, 3) == 0));
        bus.bmem_rvalid = drop;
        bus.bmem_raddr  = drop_addr;
        bus.bmem_rdata  = {$urandom, $urandom};
        exp_stall++;
        if (drop) exp_drop++;
        step();
      end
      if (i == abort_after) begin
        bus.dfp_read    = 1'b0;
        bus.bmem_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("midreset");
        @(posedge clk);
        #1;
        check("midreset_noresp", bus.dfp_resp, 1'b0);
        rst_n = 1'b1;
        step();
        check("midreset_idle", bus.dfp_resp, 1'b0);
        return;
      end
      exp_line[i] = {$urandom, $urandom};
      check("rd_beat_noresp", bus.dfp_resp, 1'b0);
      bus.bmem_rvalid = 1'b1;
      bus.bmem_raddr  = aligned;
      bus.bmem_rdata  = exp_line[i];
      step();
    end
    bus.bmem_rvalid = 1'b0;
    exp_rdata = exp_line;
    exp_rd++;
    check("rd_resp",  bus.dfp_resp,  1'b1);
    check("rd_rdata", bus.dfp_rdata, exp_rdata);
    bus.dfp_read = 1'b0;
    step();
    check("rd_resp_pulse", bus.dfp_resp,  1'b0);
    check("rd_rdata_hold", bus.dfp_rdata, exp_rdata);
  endtask

  initial begin
    line_beats_t l;
    checks = 0;
    errors = 0;
    cyc    = 0;
    bus.dfp_addr   = '0;
    bus.dfp_wdata  = '0;
    bus.bmem_raddr = '0;
    bus.bmem_rdata = '0;
    idle_inputs();
    rst_n = 1'b1;
    #3;

    // Reset state
    do_reset();
    check_zero("post_reset");

    // Directed write, memory always ready, then immediate refill read with 2-cycle gaps
    l[0] = 64'h1111_1111_0000_0000;
    l[1] = 64'h2222_2222_0000_0001;
    l[2] = 64'h3333_3333_0000_0002;
    l[3] = 64'h4444_4444_0000_0003;
    do_write(32'h0000_1234, l, 1'b0);
    do_read(32'h0000_8040, 0, 2, 1'b0, -1, -1);
    check_perf("wb_refill");

    // bmem_ready low for 3 cycles in READ_REQ
    do_reset();
    do_read(32'h0000_4000, 3, 0, 1'b0, -1, -1);
    check_perf("req_stall");

    // Interleaved beat from a foreign line is dropped
    do_reset();
    do_read(32'h0001_0020, 0, 0, 1'b0, 2, -1);
    check_perf("drop");

    // Reset mid-READ_WAIT after two beats, then a fresh full read
    do_read(32'h0002_0000, 0, 0, 1'b0, -1, 2);
    check_zero("after_abort");
    do_read(32'h0002_0000, 0, 0, 1'b0, -1, -1);
    check_perf("fresh_read");

    // Randomized mix, mostly back-to-back
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1) do_write($urandom, rand_line(), 1'b1);
      else do_read($urandom, int'($urandom_range(0, 2)), 0, 1'b1, -1, -1);
      if ($urandom_range(0, 3) == 0) step();
    end
    check_perf("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dfp_line_bridge.md
# dfp_line_bridge

Downstream responder for the cache's `dfp` port. It accepts one 256-bit line read or write from the cache and services it against a 64-bit burst memory (`bmem`) as four beats. It returns a single-cycle `dfp_resp` when the line transfer is complete. It sits between the mutative cache and the burst memory model / memory controller.

## Interface
- `BEATS`, 4 — beats per line (256 / `BURST_W`)
- `BURST_W`, 64 — burst bus data width
- `clk`  in  1 — clock, all state on rising edge
- `rst_n`  in  1 — reset is asynchronous and active-low
- `dfp_addr`  in  32 — line address from cache; bits [4:0] ignored
- `dfp_read`  in  1 — line read request, held until `dfp_resp`
- `dfp_write`  in  1 — line write request, held until `dfp_resp`
- `dfp_wdata`  in  256 — write line, valid with `dfp_write`
- `dfp_rdata`  out  256 — assembled read line, valid with `dfp_resp`
- `dfp_resp`  out  1 — one-cycle completion pulse
- `bmem_addr`  out  32 — aligned line address ({addr[31:5], 5'b0})
- `bmem_read`  out  1 — burst read command
- `bmem_write`  out  1 — write beat valid
- `bmem_wdata`  out  64 — write beat
- `bmem_ready`  in  1 — memory accepts command/beat this cycle
- `bmem_raddr`  in  32 — line address tagging returned beat
- `bmem_rdata`  in  64 — returned read beat
- `bmem_rvalid`  in  1 — read beat valid

## Operation
- FSM states: IDLE, WRITE, READ_REQ, READ_WAIT, RESP.
- IDLE:
  - `dfp_write` → latch aligned addr + wdata; beat counter = 0; go to WRITE.
  - Else `dfp_read` → latch aligned addr; go to READ_REQ.
  - Both asserted: write wins (protocol violation; the cache never does this).
- WRITE:
  - `bmem_write`=1, `bmem_wdata` = latched line[64*cnt +: 64], `bmem_addr` = latched line addr.
  - Counter advances only when `bmem_ready`=1.
  - Beat `BEATS-1` accepted → RESP.
- READ_REQ:
  - `bmem_read`=1 and `bmem_addr` held until `bmem_ready`=1.
  - Then counter = 0 → READ_WAIT.
- READ_WAIT:
  - Each `bmem_rvalid` with `bmem_raddr` == latched addr writes `bmem_rdata` into line[64*cnt +: 64], then cnt++.
  - Beats with mismatched `raddr` are dropped.
  - Last beat stored → RESP.
- RESP: `dfp_resp`=1 for exactly one cycle → IDLE. Requests are not sampled in RESP.
- `dfp_rdata` holds its value until the next read completes. A write does not disturb it.
- Beat counter is 2 bits (log2 `BEATS`) and must not wrap before the state exit.

## Timing
- Reset (async, any state): state=IDLE; `dfp_resp`, `bmem_read`, `bmem_write`=0; `bmem_addr`, `bmem_wdata`, `dfp_rdata`, counters=0.
- Reset mid-burst discards the partial line. No response is issued.
- Write, memory always ready: request sampled at cycle 0; beats on cycles 1–4; `dfp_resp` on cycle 5.
- Read, minimum latency: `bmem_read` on cycle 1; beats on cycles 2–5; `dfp_resp` on cycle 6. Extra `bmem_ready`/`rvalid` gaps add 1 cycle each.
- After `dfp_resp` the requester may present a new request on the very next cycle; IDLE samples it then. This supports writeback followed immediately by refill.
- `bmem_rvalid` outside READ_WAIT is ignored.

## Configuration
- `DFP_BRIDGE_PERF_EN` defined: adds outputs `perf_rd_lines` (32), `perf_wr_lines` (32), `perf_stall_cycles` (32) and `perf_drop_beats` (16).
  - All counters saturate and reset to 0.
  - Stall = cycle in WRITE/READ_REQ with `bmem_ready`=0, or in READ_WAIT with no accepted beat.
- Undefined: these ports and counters do not exist; functional behaviour is identical.

## Structure
- In `mutative_types`:
  - `BRIDGE_BEATS` and `BRIDGE_BURST_W`.
  - `bridge_state_t` enum.
  - `line_beats_t` (packed array `[BEATS-1:0][BURST_W-1:0]`).
- One sub-module, `dfp_beat_buffer`: a 256-bit line register with beat-indexed write and read (load-all, write-beat, read-beat).
- The FSM and counters stay in the top module.

## Test plan
- Reset mid-READ_WAIT after 2 beats → all outputs 0 immediately; no `dfp_resp`; the next read returns a full fresh line.
- Write `dfp_addr`=0x0000_1234 with line=4 distinct 64-bit words, `bmem_ready`=1 → `bmem_addr`=0x0000_1220 for all 4 beats, beats in order [63:0] first; `dfp_resp` on cycle 5.
- Read 0x0000_8040, memory returns beats A, B, C, D with 2-cycle gaps → `dfp_rdata`={D,C,B,A}; single `dfp_resp` pulse.
- Read with an interleaved beat carrying `bmem_raddr`=0xDEAD_0000 → beat dropped, line correct; `perf_drop_beats`=1 when `DFP_BRIDGE_PERF_EN` is defined.
- Write immediately followed by a read on the cycle after `dfp_resp` (writeback then refill) → the read is accepted without an idle gap, and both complete.
- `bmem_ready` held low 3 cycles in READ_REQ → `bmem_read` and `bmem_addr` stay stable; `perf_stall_cycles`=3.
